// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the miniCPU fetch stage: FSM encodings, IR field
// positions and the opcode values the rest of the core agrees on.
package pc_fetch_unit_pkg;

  localparam int XLEN = 32;

  // Fetch FSM encodings (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] FETCH_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_FETCH = 2'd1;
  localparam logic [1:0] FETCH_EXEC  = 2'd2;
  localparam logic [1:0] FETCH_HALT  = 2'd3;

  localparam int OP1_MSB = 31;
  localparam int OP1_LSB = 24;
  localparam int OP2_MSB = 23;
  localparam int OP2_LSB = 22;
  localparam int OP3_MSB = 21;
  localparam int OP3_LSB = 19;

  localparam logic [7:0] zB   = 8'h20;
  localparam logic [7:0] zBcc = 8'h21;
  localparam logic [7:0] zHLT = 8'hFF;

  typedef struct packed {
    logic [7:0] op1;
    logic [1:0] op2;
    logic [2:0] op3;
  } op_fields_t;

  function automatic op_fields_t split_ir(input logic [XLEN-1:0] word);
    op_fields_t f;
    f.op1 = word[OP1_MSB:OP1_LSB];
    f.op2 = word[OP2_MSB:OP2_LSB];
    f.op3 = word[OP3_MSB:OP3_LSB];
    return f;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port: req/addr from the fetch unit, ack/rdata back.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches one word per
// instruction, holds it in the IR and commits next_pc on execution completion.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   n_rst,
  pc_fetch_unit_if.master        mem,
  input  logic [XLEN-1:0]        next_pc,
  input  logic                   exec_done,
  input  logic                   halt,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        ir,
  output logic [7:0]             op1,
  output logic [1:0]             op2,
  output logic [2:0]             op3,
  output logic                   ir_valid,
  output logic                   halted,
  output logic [XLEN-1:0]        instr_count
);

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] ir_reg, ir_next;
  logic            ir_valid_reg, ir_valid_next;
  logic            halted_reg, halted_next;
  logic [XLEN-1:0] count_reg, count_next;
  op_fields_t      fields;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_valid_next = ir_valid_reg;
    halted_next   = halted_reg;
    count_next    = count_reg;

    case (state_reg)
      FETCH_IDLE: begin
        state_next = FETCH_FETCH;
      end

      FETCH_FETCH: begin
        // exec_done arriving together with the ack is deliberately dropped
        if (mem.mem_ack) begin
          ir_next       = mem.mem_rdata;
          ir_valid_next = 1'b1;
          state_next    = FETCH_EXEC;
        end
      end

      FETCH_EXEC: begin
        if (exec_done) begin
          ir_valid_next = 1'b0;
          if (halt) begin
            halted_next = 1'b1;
            state_next  = FETCH_HALT;
          end else begin
            pc_next    = next_pc;
            count_next = count_reg + 32'd1;
            state_next = FETCH_FETCH;
          end
        end
      end

      default: begin
        // HALT only leaves through reset
        state_next = FETCH_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= FETCH_IDLE;
      pc_reg       <= RESET_PC;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      halted_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_valid_reg <= ir_valid_next;
      halted_reg   <= halted_next;
      count_reg    <= count_next;
    end
  end

  // All outputs come straight from registers, so reset clears them at once
  assign mem.mem_req  = (state_reg == FETCH_FETCH);
  assign mem.mem_addr = pc_reg;

  assign fields      = split_ir(ir_reg);
  assign pc          = pc_reg;
  assign ir          = ir_reg;
  assign op1         = fields.op1;
  assign op2         = fields.op2;
  assign op3         = fields.op3;
  assign ir_valid    = ir_valid_reg;
  assign halted      = halted_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised scoreboard bench for pc_fetch_unit: a memory/executor driver
// pushes expected fetches and IR words, a monitor pops and compares them.
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        exec_done = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc, ir, instr_count;
  logic [7:0]  op1;
  logic [1:0]  op2;
  logic [2:0]  op3;
  logic        ir_valid, halted;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .mem        (bus.master),
    .next_pc    (next_pc),
    .exec_done  (exec_done),
    .halt       (halt),
    .pc         (pc),
    .ir         (ir),
    .op1        (op1),
    .op2        (op2),
    .op3        (op3),
    .ir_valid   (ir_valid),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] cnt;
  } fetch_t;

  int          checks = 0;
  int          errors = 0;
  fetch_t      fetch_q[$];
  logic [31:0] ir_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          mon_en = 1'b0;

  task automatic fail_msg(input string name, input logic [31:0] act, input logic [31:0] exp);
    errors++;
    $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) fail_msg(name, act, exp);
  endtask

  // Instruction memory contents
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hA1C8_0000;
      32'h0000_0007: return {zHLT, 24'h0};
      32'h0000_0040: return {zB, 24'h000123};
      default:       return a * 32'h9E37_79B9 + 32'h1357_9BDF;
    endcase
  endfunction

  // Monitor: every new fetch request and every fresh IR must match the model
  initial begin : monitor
    logic   prev_req;
    logic   prev_iv;
    fetch_t f;
    logic [31:0] w;
    prev_req = 1'b0;
    prev_iv  = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.mem_req && !prev_req) begin
          if (fetch_q.size() == 0) begin
            checks++;
            fail_msg("unexpected_fetch", bus.mem_addr, 32'h0);
          end else begin
            f = fetch_q.pop_front();
            chk("fetch_addr", bus.mem_addr, f.addr);
            chk("fetch_pc", pc, f.addr);
            chk("fetch_count", instr_count, f.cnt);
            chk("fetch_irv", 32'(ir_valid), 32'd0);
          end
        end
        if (ir_valid && !prev_iv) begin
          if (ir_q.size() == 0) begin
            checks++;
            fail_msg("unexpected_ir", ir, 32'h0);
          end else begin
            w = ir_q.pop_front();
            chk("ir_word", ir, w);
            chk("ir_op1", 32'(op1), 32'(w[31:24]));
            chk("ir_op2", 32'(op2), 32'(w[23:22]));
            chk("ir_op3", 32'(op3), 32'(w[21:19]));
          end
        end
      end
      prev_req = bus.mem_req;
      prev_iv  = ir_valid;
    end
  end

  // Serve one fetch (called at a negedge) and then retire or halt it
  task automatic run_instr(input int waits, input logic [31:0] npc, input bit hlt);
    int          n;
    int          ew;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] ir_before;
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_req) begin
      checks++;
      fail_msg("req_timeout", 32'd0, 32'd1);
      return;
    end
    a = bus.mem_addr;
    w = memfn(a);
    ir_before = ir;
    for (int i = 0; i < waits; i++) begin
      exec_done = ($urandom_range(0, 3) == 0);
      halt      = 1'($urandom_range(0, 1));
      next_pc   = $urandom;
      @(negedge clk);
      chk("wait_req", 32'(bus.mem_req), 32'd1);
      chk("wait_addr", bus.mem_addr, a);
      chk("wait_ir", ir, ir_before);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = w;
    exec_done     = 1'($urandom_range(0, 1));
    halt          = 1'($urandom_range(0, 1));
    next_pc       = $urandom;
    ir_q.push_back(w);
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    exec_done     = 1'b0;
    halt          = 1'b0;
    ew = $urandom_range(0, 2);
    for (int i = 0; i < ew; i++) begin
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = ~w;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
    end
    chk("exec_ir_hold", ir, w);
    chk("exec_pc", pc, m_pc);
    exec_done = 1'b1;
    next_pc   = npc;
    halt      = hlt;
    if (!hlt) begin
      m_pc    = npc;
      m_count = m_count + 32'd1;
      fetch_q.push_back('{npc, m_count});
    end
    @(negedge clk);
    exec_done = 1'b0;
    halt      = 1'b0;
    next_pc   = $urandom;
    $display("INSTR addr=%08h word=%08h waits=%0d next=%08h halt=%0d", a, w, waits, npc, hlt);
  endtask

  task automatic assert_reset();
    #2;
    n_rst = 1'b0;
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_irv", 32'(ir_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ir", ir, 32'd0);
    fetch_q.delete();
    ir_q.delete();
    m_pc    = RST_PC;
    m_count = 32'd0;
    fetch_q.push_back('{RST_PC, 32'd0});
  endtask

  // Release reset with a stale ack that must be ignored in IDLE
  task automatic release_reset();
    @(negedge clk);
    #2;
    n_rst         = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    chk("late_ack_irv", 32'(ir_valid), 32'd0);
    chk("late_ack_ir", ir, 32'd0);
    chk("first_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    logic [31:0] npc;
    int          r;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    m_pc    = RST_PC;
    m_count = 32'd0;
    fetch_q.push_back('{RST_PC, 32'd0});

    #3;
    chk("reset_req", 32'(bus.mem_req), 32'd0);
    chk("reset_pc", pc, RST_PC);
    chk("reset_ir", ir, 32'd0);
    chk("reset_op1", 32'(op1), 32'd0);
    chk("reset_op2", 32'(op2), 32'd0);
    chk("reset_op3", 32'(op3), 32'd0);
    chk("reset_irv", 32'(ir_valid), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    mon_en = 1'b1;

    #19;
    n_rst = 1'b1;
    #1;
    chk("idle_no_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'd0);

    run_instr(0, 32'd1, 1'b0);
    chk("tp_ir", ir, 32'hA1C8_0000);
    chk("tp_op1", 32'(op1), 32'h0000_00A1);
    chk("tp_op2", 32'(op2), 32'd3);
    chk("tp_op3", 32'(op3), 32'd1);
    run_instr(0, 32'd2, 1'b0);
    chk("seq_count", instr_count, 32'd2);
    run_instr(5, 32'd4, 1'b0);
    run_instr(0, 32'h40, 1'b0);
    chk("branch_addr", bus.mem_addr, 32'h40);
    chk("branch_req", 32'(bus.mem_req), 32'd1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       npc = m_pc + 32'd1;
        1:       npc = $urandom;
        2:       npc = 32'hFFFF_FFFF;
        default: npc = 32'h0;
      endcase
      run_instr($urandom_range(0, 3), npc, 1'b0);
    end

    run_instr(1, 32'd7, 1'b0);
    run_instr(2, 32'h1234, 1'b1);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_irv", 32'(ir_valid), 32'd0);
    chk("hlt_pc", pc, 32'd7);
    for (int k = 0; k < 20; k++) begin
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      exec_done     = 1'($urandom_range(0, 1));
      halt          = 1'($urandom_range(0, 1));
      next_pc       = $urandom;
      @(negedge clk);
      chk("hlt_req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_ack = 1'b0;
    exec_done   = 1'b0;
    halt        = 1'b0;
    chk("hlt_pc_hold", pc, 32'd7);
    chk("hlt_count", instr_count, m_count);
    chk("hlt_sticky", 32'(halted), 32'd1);

    assert_reset();
    release_reset();
    run_instr(0, 32'd9, 1'b0);
    chk("mid_req", 32'(bus.mem_req), 32'd1);
    chk("mid_pc", pc, 32'd9);
    assert_reset();
    release_reset();
    run_instr(0, 32'd1, 1'b0);
    run_instr(1, 32'd2, 1'b0);
    repeat (2) @(negedge clk);
    chk("drain_fetch", 32'(fetch_q.size()), 32'd0);
    chk("drain_ir", 32'(ir_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
